// File: rtl/pll_reconf_loader.sv
// Initiator for the PLL reconfiguration ROM: reads the scan image, shifts it into the PLL and applies it.
// Define PLL_RECONF_TIMEOUT_EN to add a scandone watchdog of TIMEOUT_CYCLES cycles in WAIT_DONE.
module pll_reconf_loader #(
    parameter int SCAN_LEN       = 144,
    parameter int ROM_LATENCY    = 2,
    parameter int RECONF_DELAY   = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] rom_address,
    output logic       rom_read_ena,
    input  logic       rom_q,
    input  logic       rom_reconfig,
    output logic       pll_scanclkena,
    output logic       pll_scandata,
    output logic       pll_configupdate,
    input  logic       pll_scandone,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_DRAIN, S_WAIT_RECONF, S_UPDATE, S_WAIT_DONE, S_DONE, S_ERROR
    } state_t;

    localparam logic [7:0] LAST_ADDR    = 8'(SCAN_LEN - 1);
    localparam logic [7:0] RECONF_EARLY = 8'(RECONF_DELAY - 1);
    localparam logic [7:0] RECONF_LATE  = 8'(RECONF_DELAY + 1);

    if (SCAN_LEN < 1 || SCAN_LEN > 256 || ROM_LATENCY < 1 || RECONF_DELAY < 1 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8192) begin : g_bad_params
        $error("pll_reconf_loader: unsupported parameter set");
    end

    state_t                 r_state;
    state_t                 w_state_next;
    logic [7:0]             r_addr;
    logic [7:0]             r_cnt;     // cycles since read_ena fell, then the scandone blanking flag
    logic [ROM_LATENCY-1:0] r_rd_dly;
    logic [ROM_LATENCY-1:0] w_rd_dly_next;
    logic                   r_error;

`ifdef PLL_RECONF_TIMEOUT_EN
    localparam logic [12:0] TIMEOUT_LAST = 13'(TIMEOUT_CYCLES - 1);
    logic [12:0] r_wdog;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wdog <= '0;
        end else if (r_state == S_UPDATE) begin
            r_wdog <= '0;
        end else if (r_state == S_WAIT_DONE) begin
            r_wdog <= r_wdog + 13'd1;
        end
    end
`endif

    // read_ena delayed by the ROM latency marks exactly the cycles on which rom_q is a scan bit
    assign w_rd_dly_next = (r_rd_dly << 1) | ROM_LATENCY'(rom_read_ena);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:        if (start) w_state_next = S_READ;
            S_READ:        if (r_addr == LAST_ADDR) w_state_next = S_DRAIN;
            S_DRAIN:       if (w_rd_dly_next == '0) w_state_next = S_WAIT_RECONF;
            S_WAIT_RECONF: begin
                if (rom_reconfig) begin
                    w_state_next = (r_cnt >= RECONF_EARLY) ? S_UPDATE : S_ERROR;
                end else if (r_cnt >= RECONF_LATE) begin
                    w_state_next = S_ERROR;
                end
            end
            S_UPDATE:      w_state_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                // scandone is blanked on the strobe cycle and the one after while the PLL drops it
                if (pll_scandone && (r_cnt != '0)) begin
                    w_state_next = S_DONE;
                end
`ifdef PLL_RECONF_TIMEOUT_EN
                else if (r_wdog == TIMEOUT_LAST) begin
                    w_state_next = S_ERROR;
                end
`else
                // without the watchdog the loader waits for scandone indefinitely
`endif
            end
            S_DONE:        w_state_next = S_IDLE;
            S_ERROR:       w_state_next = S_IDLE;
            default:       w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_rd_dly <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rd_dly <= w_rd_dly_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= '0;
                        r_error <= 1'b0;
                    end
                end
                S_READ: begin
                    if (r_addr != LAST_ADDR) r_addr <= r_addr + 8'd1;
                    else                     r_cnt  <= '0;
                end
                S_DRAIN, S_WAIT_RECONF: r_cnt <= r_cnt + 8'd1;
                S_UPDATE:               r_cnt <= '0;
                S_WAIT_DONE:            r_cnt <= 8'd1;
                default: ;
            endcase
            if (w_state_next == S_ERROR) r_error <= 1'b1;
        end
    end

    assign rom_address      = r_addr;
    assign rom_read_ena     = (r_state == S_READ);
    assign pll_scanclkena   = r_rd_dly[ROM_LATENCY-1] && (r_state != S_ERROR);
    assign pll_scandata     = pll_scanclkena & rom_q;
    assign pll_configupdate = (r_state == S_UPDATE);
    assign busy             = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
    assign done             = (r_state == S_DONE);
    assign error            = r_error;

endmodule

// File: tb/tb_pll_reconf_loader.sv
// Scoreboard bench for pll_reconf_loader with a latency-2 ROM model and a behavioural PLL scandone model.
module tb_pll_reconf_loader;

    localparam logic [143:0] ROM_PAT = 144'hA5C3_0FF0_1234_5678_9ABC_DEF0_8001_7E3C_96E1;

    typedef struct {
        int   cyc;
        logic val;
    } scan_exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] rom_address;
    logic       rom_read_ena;
    logic       rom_q;
    logic       rom_reconfig;
    logic       pll_scanclkena;
    logic       pll_scandata;
    logic       pll_configupdate;
    logic       pll_scandone;
    logic       busy;
    logic       done;
    logic       error;

    logic [143:0] rom_img = ROM_PAT;
    scan_exp_t    scan_q[$];
    int           cfg_q[$];
    int           done_q[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           n_rd = 0;
    int           n_cfg = 0;

    logic [7:0] p1_addr = '0;
    logic [7:0] p2_addr = '0;
    logic       prev_ena = 1'b0;
    logic [2:0] rc_sr = '0;
    logic       reconf_en = 1'b1;
    int         sd_cnt = 0;
    int         sd_mode = 0;   // 0: scandone 20 cycles after update, 1: held high, 2: held low

    pll_reconf_loader dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .rom_address      (rom_address),
        .rom_read_ena     (rom_read_ena),
        .rom_q            (rom_q),
        .rom_reconfig     (rom_reconfig),
        .pll_scanclkena   (pll_scanclkena),
        .pll_scandata     (pll_scandata),
        .pll_configupdate (pll_configupdate),
        .pll_scandone     (pll_scandone),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ROM: q two cycles after the address; reconfig pulse three cycles after read_ena falls
    always @(posedge clock) begin
        p1_addr  <= rom_address;
        p2_addr  <= p1_addr;
        prev_ena <= rom_read_ena;
        rc_sr    <= {rc_sr[1:0], prev_ena & ~rom_read_ena};
    end
    assign rom_q        = rom_img[p2_addr];
    assign rom_reconfig = rc_sr[2] & reconf_en;

    always @(posedge clock) begin
        if (pll_configupdate)                  sd_cnt <= 1;
        else if (sd_cnt != 0 && sd_cnt < 1000) sd_cnt <= sd_cnt + 1;
    end
    assign pll_scandone = (sd_mode == 1) || (sd_mode == 0 && sd_cnt >= 20);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a scan bit, an update strobe or done
    logic mon_prev_ena = 1'b0;
    int   rd_idx = 0;
    always @(negedge clock) begin
        scan_exp_t e;
        if (!reset) begin
            if (pll_scanclkena) begin
                if (scan_q.size() == 0) begin
                    check("scan_unexpected", pll_scanclkena, 0);
                end else begin
                    e = scan_q.pop_front();
                    check("scan_data", pll_scandata, e.val);
                    check("scan_cycle", cyc, e.cyc);
                end
            end
            if (pll_configupdate) begin
                n_cfg++;
                if (cfg_q.size() == 0) check("cfg_unexpected", pll_configupdate, 0);
                else                   check("cfg_cycle", cyc, cfg_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) check("done_unexpected", done, 0);
                else                    check("done_cycle", cyc, done_q.pop_front());
            end
            if (rom_read_ena) begin
                rd_idx = mon_prev_ena ? rd_idx + 1 : 0;
                check("rom_address", rom_address, rd_idx);
                n_rd++;
            end
            mon_prev_ena = rom_read_ena;
        end else begin
            mon_prev_ena = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        check("busy_timeout", busy, 0);
    endtask

    // Pushes the expected response of one load started this cycle, then pulses start.
    // Scan bit i at s+3+i; configupdate at s+149; done at configupdate+done_off.
    task automatic launch(input bit exp_cfg, input int done_off, output int s);
        scan_exp_t e;
        s = cyc;
        for (int i = 0; i < 144; i++) begin
            e.cyc = s + 3 + i;
            e.val = rom_img[i];
            scan_q.push_back(e);
        end
        if (exp_cfg)      cfg_q.push_back(s + 149);
        if (done_off > 0) done_q.push_back(s + 149 + done_off);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic queues_empty(input string tag);
        tick();
        tick();
        check({tag, "_scan_left"}, scan_q.size(), 0);
        check({tag, "_cfg_left"}, cfg_q.size(), 0);
        check({tag, "_done_left"}, done_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, rom_address, 0);
        check({tag, "_rdena"}, rom_read_ena, 0);
        check({tag, "_scanclkena"}, pll_scanclkena, 0);
        check({tag, "_scandata"}, pll_scandata, 0);
        check({tag, "_cfgupd"}, pll_configupdate, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int s;
        int t;
        int base;
        #2;
        check_all_zero("reset");
        tick();
        tick();
        reset = 1'b0;
        tick();

        // normal load, scandone 20 cycles after update
        launch(1'b1, 21, s);
        wait_idle(400);
        check("t1_error", error, 0);
        queues_empty("t1");

        // back-to-back starts: second ignored, exactly 144 reads
        base = n_rd;
        launch(1'b1, 21, s);
        start = 1'b1;
        check("t2_busy_a", busy, 1);
        tick();
        start = 1'b0;
        check("t2_busy_b", busy, 1);
        wait_idle(400);
        queues_empty("t2");
        check("t2_reads", n_rd - base, 144);

        // missing reconfig pulse: error at read_ena fall + 5, then recovery
        reconf_en = 1'b0;
        launch(1'b0, 0, s);
        wait_until(s + 149);
        check("t3_error_pre", error, 0);
        check("t3_busy_pre", busy, 1);
        tick();
        check("t3_error", error, 1);
        check("t3_busy", busy, 0);
        tick();
        tick();
        reconf_en = 1'b1;
        queues_empty("t3a");
        launch(1'b1, 21, s);
        check("t3_error_cleared", error, 0);
        wait_idle(400);
        check("t3_done_error", error, 0);
        queues_empty("t3b");

        // reset at address 70 aborts; stray reconfig pulse while idle is ignored
        base = n_cfg;
        launch(1'b1, 21, s);
        wait_until(s + 71);
        check("t4_addr70", rom_address, 70);
        reset = 1'b1;
        #1;
        check_all_zero("t4_abort");
        scan_q.delete();
        cfg_q.delete();
        done_q.delete();
        tick();
        tick();
        reset = 1'b0;
        repeat (8) tick();
        check("t4_idle", busy, 0);
        check("t4_no_cfg", n_cfg - base, 0);
        launch(1'b1, 21, s);
        wait_idle(400);
        queues_empty("t4");

        // scandone held high: still blanked, done 3 cycles after configupdate
        sd_mode = 1;
        launch(1'b1, 3, s);
        wait_idle(400);
        queues_empty("t5");
        sd_mode = 0;

        // scandone held low
        sd_mode = 2;
`ifdef PLL_RECONF_TIMEOUT_EN
        launch(1'b1, 0, s);
        wait_until(s + 149 + 4096);
        check("t6_error_pre", error, 0);
        check("t6_busy_pre", busy, 1);
        tick();
        check("t6_error", error, 1);
        check("t6_busy", busy, 0);
        sd_mode = 0;
        queues_empty("t6");
`else
        launch(1'b1, 0, s);
        wait_until(s + 149 + 300);
        check("t6_busy_hold", busy, 1);
        check("t6_error", error, 0);
        t = cyc;
        done_q.push_back(t + 1);
        sd_mode = 1;
        wait_idle(10);
        queues_empty("t6");
        sd_mode = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
